// File: rtl/gnw_boot_pkg.sv
// Shared types for the Game & Watch boot sequencer:
// sequencer states, ROM word counter width and its saturation limit.
package gnw_boot_pkg;

  localparam int ROM_WORDS_W = 25;
  localparam int OSD_TIMER_W = 26;

  localparam logic [ROM_WORDS_W-1:0] ROM_WORDS_MAX =
    {ROM_WORDS_W{1'b1}};

  typedef enum logic [2:0] {
    S_NO_ROM,
    S_LOADING,
    S_ERROR,
    S_HOLD,
    S_RUN
  } boot_state_e;

  function automatic logic [ROM_WORDS_W-1:0] rom_words_inc(
    input logic [ROM_WORDS_W-1:0] v
  );
    return (v == ROM_WORDS_MAX) ? v : v + ROM_WORDS_W'(1);
  endfunction

endpackage

// File: rtl/gnw_ioctl_if.sv
// HPS ROM download stream: download-active level and
// one-cycle word write strobe.
interface gnw_ioctl_if;

  logic ioctl_download;
  logic ioctl_wr;

  modport master (
    output ioctl_download,
    output ioctl_wr
  );

  modport slave (
    input ioctl_download,
    input ioctl_wr
  );

endinterface

// File: rtl/gnw_osd_request_timer.sv
// OSD-open request window: armed by the first ext_reset,
// then open for OSD_TIMEOUT idle cycles while no ROM is resident.
module gnw_osd_request_timer
  import gnw_boot_pkg::*;
#(
  parameter logic [OSD_TIMER_W-1:0] OSD_TIMEOUT = 26'h1FFFFFF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ext_reset,
  input  logic has_rom,
  output logic open_osd
);

  logic                   armed_q;
  logic                   armed_d;
  logic [OSD_TIMER_W-1:0] timer_q;
  logic [OSD_TIMER_W-1:0] timer_d;
  logic                   open_osd_q;
  logic                   open_osd_d;
  logic                   window;

  // The timer is one-shot: only reset_n ever reloads it.
  always_comb begin
    window     = armed_q & ~ext_reset & (timer_q != '0);
    armed_d    = armed_q | ext_reset;
    timer_d    = timer_q;
    if (window) begin
      timer_d = timer_q - OSD_TIMER_W'(1);
    end
    open_osd_d = window & ~has_rom;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q    <= 1'b0;
      timer_q    <= OSD_TIMEOUT;
      open_osd_q <= 1'b0;
    end else begin
      armed_q    <= armed_d;
      timer_q    <= timer_d;
      open_osd_q <= open_osd_d;
    end
  end

  assign open_osd = open_osd_q;

endmodule

// File: rtl/gnw_boot_sequencer.sv
// Owns core reset and ROM-present state: counts the HPS ROM download,
// validates its size and stretches core reset after every reset cause.
module gnw_boot_sequencer
  import gnw_boot_pkg::*;
#(
  parameter logic [OSD_TIMER_W-1:0] OSD_TIMEOUT   = 26'h1FFFFFF,
  parameter int                     RESET_HOLD    = 1024,
  parameter int                     MIN_ROM_WORDS = 16
) (
  input  logic                   clk_sys_99_287,
  input  logic                   reset_n,
  input  logic                   pll_locked,
  gnw_ioctl_if.slave             ioctl,
  input  logic                   ext_reset,
  input  logic                   user_reset,
  output logic                   core_reset,
  output logic                   has_rom,
  output logic                   load_error,
  output logic [ROM_WORDS_W-1:0] rom_words,
  output logic                   open_osd
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD - 1);

  localparam logic [ROM_WORDS_W-1:0] MIN_WORDS =
    ROM_WORDS_W'(MIN_ROM_WORDS);

  boot_state_e            state_q;
  boot_state_e            state_d;
  logic [HOLD_W-1:0]      hold_q;
  logic [HOLD_W-1:0]      hold_d;
  logic [ROM_WORDS_W-1:0] rom_words_q;
  logic [ROM_WORDS_W-1:0] rom_words_d;
  logic                   has_rom_q;
  logic                   has_rom_d;
  logic                   load_error_q;
  logic                   load_error_d;
  logic                   core_reset_q;
  logic                   core_reset_d;
  logic                   dl_q;
  logic                   dl_d;

  logic dl_rise;
  logic dl_fall;
  logic cause;

  always_comb begin
    dl_d         = ioctl.ioctl_download;
    dl_rise      = ioctl.ioctl_download & ~dl_q;
    dl_fall      = ~ioctl.ioctl_download & dl_q;
    cause        = ext_reset | user_reset | ~pll_locked;
    state_d      = state_q;
    hold_d       = hold_q;
    rom_words_d  = rom_words_q;
    has_rom_d    = has_rom_q;
    load_error_d = load_error_q;

    if (dl_rise) begin
      state_d      = S_LOADING;
      rom_words_d  = '0;
      has_rom_d    = 1'b0;
      load_error_d = 1'b0;
    end else begin
      unique case (state_q)
        S_LOADING: begin
          if (dl_fall) begin
            if (rom_words_q >= MIN_WORDS) begin
              state_d      = S_HOLD;
              hold_d       = HOLD_INIT;
              has_rom_d    = 1'b1;
              load_error_d = 1'b0;
            end else begin
              state_d      = S_ERROR;
              load_error_d = 1'b1;
            end
          end else if (ioctl.ioctl_wr) begin
            rom_words_d = rom_words_inc(rom_words_q);
          end
        end
        S_HOLD: begin
          if (cause) begin
            hold_d = HOLD_INIT;
          end else if (hold_q == '0) begin
            state_d = S_RUN;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
        S_RUN: begin
          if (cause) begin
            state_d = S_HOLD;
            hold_d  = HOLD_INIT;
          end
        end
        S_NO_ROM,
        S_ERROR: begin
          state_d = state_q;
        end
        default: begin
          state_d = S_NO_ROM;
        end
      endcase
    end

    // Assert as soon as RUN is left; release one edge after RUN is entered.
    core_reset_d = (state_q != S_RUN) | (state_d != S_RUN);
  end

  always_ff @(posedge clk_sys_99_287 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_NO_ROM;
      hold_q       <= '0;
      rom_words_q  <= '0;
      has_rom_q    <= 1'b0;
      load_error_q <= 1'b0;
      core_reset_q <= 1'b1;
      dl_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      rom_words_q  <= rom_words_d;
      has_rom_q    <= has_rom_d;
      load_error_q <= load_error_d;
      core_reset_q <= core_reset_d;
      dl_q         <= dl_d;
    end
  end

  gnw_osd_request_timer #(
    .OSD_TIMEOUT (OSD_TIMEOUT)
  ) u_osd_timer (
    .clk       (clk_sys_99_287),
    .rst_n     (reset_n),
    .ext_reset (ext_reset),
    .has_rom   (has_rom_q),
    .open_osd  (open_osd)
  );

  assign core_reset = core_reset_q;
  assign has_rom    = has_rom_q;
  assign load_error = load_error_q;
  assign rom_words  = rom_words_q;

endmodule

// File: tb/tb_gnw_boot_sequencer.sv
// Bench for gnw_boot_sequencer: directed scenarios plus random traffic
// against a phase-level reference model.
module tb_gnw_boot_sequencer;

  localparam int OSD_T   = 8;
  localparam int HOLD    = 4;
  localparam int MIN_W   = 4;
  localparam int SAT_MAX = 33554431;

  localparam int P_EMPTY  = 0;
  localparam int P_LOAD   = 1;
  localparam int P_BAD    = 2;
  localparam int P_SETTLE = 3;
  localparam int P_RUN    = 4;

  localparam logic [28:0] RST_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 25'd0};

  logic        clk;
  logic        reset_n;
  logic        pll;
  logic        ext;
  logic        usr;
  logic        core_reset;
  logic        has_rom;
  logic        load_error;
  logic [24:0] rom_words;
  logic        open_osd;

  gnw_ioctl_if ioctl ();

  gnw_boot_sequencer #(
    .OSD_TIMEOUT   (26'd8),
    .RESET_HOLD    (HOLD),
    .MIN_ROM_WORDS (MIN_W)
  ) dut (
    .clk_sys_99_287 (clk),
    .reset_n        (reset_n),
    .pll_locked     (pll),
    .ioctl          (ioctl),
    .ext_reset      (ext),
    .user_reset     (usr),
    .core_reset     (core_reset),
    .has_rom        (has_rom),
    .load_error     (load_error),
    .rom_words      (rom_words),
    .open_osd       (open_osd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int m_phase;
  int m_quiet;
  int m_words;
  int m_osd_left;
  bit m_rom;
  bit m_err;
  bit m_prev_dl;
  bit m_armed;
  bit m_open;
  bit m_core;

  function automatic void model_reset();
    m_phase    = P_EMPTY;
    m_quiet    = 0;
    m_words    = 0;
    m_osd_left = OSD_T;
    m_rom      = 0;
    m_err      = 0;
    m_prev_dl  = 0;
    m_armed    = 0;
    m_open     = 0;
    m_core     = 1;
  endfunction

  // One clock edge of the intended behaviour, in terms of load phases
  // and a count of consecutive quiet cycles while settling.
  function automatic void model_step();
    bit dl;
    bit rise;
    bit fall;
    bit cause;
    bit was_run;
    if (!reset_n) begin
      model_reset();
      return;
    end
    dl    = ioctl.ioctl_download;
    rise  = dl && !m_prev_dl;
    fall  = !dl && m_prev_dl;
    cause = ext || usr || !pll;
    m_open = m_armed && !ext && (m_osd_left > 0) && !m_rom;
    if (m_armed && !ext && m_osd_left > 0) m_osd_left--;
    if (ext) m_armed = 1;
    was_run = (m_phase == P_RUN);
    if (rise) begin
      m_phase = P_LOAD;
      m_words = 0;
      m_rom   = 0;
      m_err   = 0;
    end else if (m_phase == P_LOAD) begin
      if (fall) begin
        if (m_words >= MIN_W) begin
          m_phase = P_SETTLE;
          m_quiet = 0;
          m_rom   = 1;
          m_err   = 0;
        end else begin
          m_phase = P_BAD;
          m_err   = 1;
        end
      end else if (ioctl.ioctl_wr && m_words < SAT_MAX) begin
        m_words++;
      end
    end else if (m_phase == P_SETTLE) begin
      if (cause) m_quiet = 0;
      else m_quiet++;
      if (m_quiet == HOLD) m_phase = P_RUN;
    end else if (m_phase == P_RUN && cause) begin
      m_phase = P_SETTLE;
      m_quiet = 0;
    end
    m_core    = !(was_run && m_phase == P_RUN);
    m_prev_dl = dl;
  endfunction

  function automatic logic [28:0] dut_vec();
    return {core_reset, has_rom, load_error, open_osd, rom_words};
  endfunction

  function automatic logic [28:0] model_vec();
    logic [31:0] w;
    w = m_words;
    return {m_core, m_rom, m_err, m_open, w[24:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic hw_reset();
    reset_n = 1'b0;
    pll = 1'b1;
    ext = 1'b0;
    usr = 1'b0;
    ioctl.ioctl_download = 1'b0;
    ioctl.ioctl_wr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    hw_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (dut_vec() !== RST_VEC) begin
      n_err++;
      $display("FAIL reset_vals: got %h want %h", dut_vec(), RST_VEC);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (dut_vec() !== model_vec()) begin
        n_err++;
        $display("FAIL reset_idle: got %h want %h", dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_valid_load();
    int lat;
    ioctl.ioctl_download = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ioctl.ioctl_wr = (i >= 2 && i < 8);
      tick();
      n_vec++;
      if (dut_vec() !== model_vec()) begin
        n_err++;
        $display("FAIL load_stream: got %h want %h", dut_vec(), model_vec());
      end
    end
    ioctl.ioctl_wr = 1'b0;
    ioctl.ioctl_download = 1'b0;
    tick();
    n_vec++;
    if ({has_rom, load_error, rom_words} !== {1'b1, 1'b0, 25'd6}) begin
      n_err++;
      $display("FAIL load_result: got rom=%b err=%b words=%0d want 1 0 6",
               has_rom, load_error, rom_words);
    end
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      if (core_reset === 1'b0) lat = i;
      else tick();
    end
    n_vec++;
    if (lat != 6) begin
      n_err++;
      $display("FAIL load_release: core_reset low %0d cycles after fall, want 5",
               lat - 1);
    end
  endtask

  task automatic test_short_load();
    int lat;
    ioctl.ioctl_download = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ioctl.ioctl_wr = (i >= 1 && i < 4);
      tick();
    end
    ioctl.ioctl_wr = 1'b0;
    ioctl.ioctl_download = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_vec++;
      if ({core_reset, has_rom, load_error} !== 3'b101) begin
        n_err++;
        $display("FAIL short_load: got rst=%b rom=%b err=%b want 1 0 1",
                 core_reset, has_rom, load_error);
      end
    end
    ioctl.ioctl_download = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ioctl.ioctl_wr = (i >= 1 && i < 6);
      tick();
    end
    ioctl.ioctl_wr = 1'b0;
    ioctl.ioctl_download = 1'b0;
    tick();
    n_vec++;
    if ({has_rom, load_error, rom_words} !== {1'b1, 1'b0, 25'd5}) begin
      n_err++;
      $display("FAIL retry_load: got rom=%b err=%b words=%0d want 1 0 5",
               has_rom, load_error, rom_words);
    end
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      tick();
      if (core_reset === 1'b0) lat = i;
    end
    n_vec++;
    if (lat == 0) begin
      n_err++;
      $display("FAIL retry_run: core_reset still %b after 12 cycles, want 0",
               core_reset);
    end
  endtask

  task automatic test_reset_stretch();
    int lat;
    usr = 1'b1;
    tick();
    n_vec++;
    if (core_reset !== 1'b1) begin
      n_err++;
      $display("FAIL stretch_assert: got %b want 1", core_reset);
    end
    repeat (2) tick();
    usr = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      tick();
      if (core_reset === 1'b0) lat = i;
    end
    n_vec++;
    if (lat != HOLD + 1) begin
      n_err++;
      $display("FAIL stretch_len: released after %0d cycles want %0d",
               lat, HOLD + 1);
    end
    usr = 1'b1;
    tick();
    usr = 1'b0;
    repeat (2) tick();
    pll = 1'b0;
    tick();
    pll = 1'b1;
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      tick();
      if (core_reset === 1'b0) lat = i;
    end
    n_vec++;
    if (lat != HOLD + 1) begin
      n_err++;
      $display("FAIL pll_glitch: released after %0d cycles want %0d",
               lat, HOLD + 1);
    end
  endtask

  task automatic test_reload_mid_run();
    ioctl.ioctl_download = 1'b1;
    ioctl.ioctl_wr = 1'b1;
    tick();
    n_vec++;
    if ({core_reset, has_rom, rom_words} !== {1'b1, 1'b0, 25'd0}) begin
      n_err++;
      $display("FAIL reload: got rst=%b rom=%b words=%0d want 1 0 0",
               core_reset, has_rom, rom_words);
    end
    for (int i = 0; i < 5; i++) begin
      ioctl.ioctl_wr = (i < 4);
      tick();
    end
    ioctl.ioctl_wr = 1'b0;
    ioctl.ioctl_download = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++;
      if (dut_vec() !== model_vec()) begin
        n_err++;
        $display("FAIL reload_tail: got %h want %h", dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_osd();
    int cnt;
    hw_reset();
    ext = 1'b1;
    repeat (2) tick();
    ext = 1'b0;
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (open_osd === 1'b1) cnt++;
      n_vec++;
      if (dut_vec() !== model_vec()) begin
        n_err++;
        $display("FAIL osd_trace: got %h want %h", dut_vec(), model_vec());
      end
    end
    n_vec++;
    if (cnt != OSD_T || open_osd !== 1'b0) begin
      n_err++;
      $display("FAIL osd_window: high %0d cycles, last %b want %0d, 0",
               cnt, open_osd, OSD_T);
    end
    hw_reset();
    ioctl.ioctl_download = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ioctl.ioctl_wr = (i >= 1 && i < 5);
      tick();
    end
    ioctl.ioctl_wr = 1'b0;
    ioctl.ioctl_download = 1'b0;
    repeat (8) tick();
    ext = 1'b1;
    repeat (2) tick();
    ext = 1'b0;
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (open_osd !== 1'b0) cnt++;
    end
    n_vec++;
    if (cnt != 0) begin
      n_err++;
      $display("FAIL osd_with_rom: open_osd high %0d cycles want 0", cnt);
    end
  endtask

  task automatic test_async_mid_load();
    hw_reset();
    ioctl.ioctl_download = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ioctl.ioctl_wr = (i >= 1);
      tick();
    end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (dut_vec() !== RST_VEC) begin
      n_err++;
      $display("FAIL async_reset: got %h want %h", dut_vec(), RST_VEC);
    end
    @(negedge clk);
    ioctl.ioctl_download = 1'b0;
    ioctl.ioctl_wr = 1'b0;
    reset_n = 1'b1;
    tick();
    ioctl.ioctl_download = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ioctl.ioctl_wr = (i >= 1 && i < 5);
      tick();
    end
    ioctl.ioctl_wr = 1'b0;
    ioctl.ioctl_download = 1'b0;
    tick();
    n_vec++;
    if ({has_rom, rom_words} !== {1'b1, 25'd4}) begin
      n_err++;
      $display("FAIL async_reload: got rom=%b words=%0d want 1 4",
               has_rom, rom_words);
    end
  endtask

  task automatic test_random();
    hw_reset();
    for (int i = 0; i < 600; i++) begin
      if (ioctl.ioctl_download) begin
        if ($urandom_range(11) == 0) ioctl.ioctl_download = 1'b0;
      end else if ($urandom_range(9) == 0) begin
        ioctl.ioctl_download = 1'b1;
      end
      ioctl.ioctl_wr = ioctl.ioctl_download & $urandom_range(1);
      usr     = ($urandom_range(29) == 0);
      ext     = ($urandom_range(39) == 0);
      pll     = ($urandom_range(39) != 0);
      reset_n = ($urandom_range(199) != 0);
      tick();
      n_vec++;
      if (dut_vec() !== model_vec()) begin
        n_err++;
        $display("FAIL random cyc %0d: got %h want %h",
                 i, dut_vec(), model_vec());
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_valid_load();
    test_short_load();
    test_reset_stretch();
    test_reload_mid_run();
    test_osd();
    test_async_mid_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
